// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit.
// Contents:
//   - opcode constants for the supported instructions
//   - FSM state enum
//   - ALU_op, ALU_srcB and PC_src encodings
//   - one-hot instruction class struct
//   - helper that identifies states which wait on memory
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StWbR,
    StWbI,
    StMemAddr,
    StMemRd,
    StMemWr,
    StMemWb,
    StBranch,
    StJump,
    StError
  } state_e;

  // One-hot instruction class; all-zero means illegal.
  typedef struct packed {
    logic r;
    logic addiu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } ins_class_t;

  function automatic logic is_mem_state(input state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier.
// Ports:
//   i_opcode  in  6  instruction[31:26]
//   o_class   out    one-hot instruction class (all zero when illegal)
//   o_illegal out 1  opcode is not supported in this configuration
module mc_opcode_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit ENABLE_BRANCH = 1'b1
) (
  input  logic [5:0] i_opcode,
  output ins_class_t o_class,
  output logic       o_illegal
);

  always_comb begin
    o_class = '0;
    unique case (i_opcode)
      OP_RTYPE: o_class.r     = 1'b1;
      OP_ADDIU: o_class.addiu = 1'b1;
      OP_ORI:   o_class.ori   = 1'b1;
      OP_LW:    o_class.lw    = 1'b1;
      OP_SW:    o_class.sw    = 1'b1;
      // Branch/jump fall back to illegal when the option is off.
      OP_BEQ:   o_class.beq   = ENABLE_BRANCH;
      OP_J:     o_class.j     = ENABLE_BRANCH;
      default:  o_class       = '0;
    endcase
  end

  assign o_illegal = ~|o_class;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back, handshakes with a
// variable-latency unified memory and traps illegal opcodes and memory
// timeouts in a sticky ERROR state (left only through reset).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   OpCode                  instruction[31:26] from the IR
//   Mem_ready               memory completes the current access
//   Mem_req, Mem_w, IorD    memory request / write / address select
//   IR_w, PC_w, PC_wcond    IR load, PC write, conditional PC write
//   PC_src, ALU_srcA/B      datapath mux selects
//   ALU_op                  ALU operation class
//   Reg_dst, Reg_w          register file destination / write
//   Mem_to_reg              write-back source
//   Illegal, Timeout        sticky error flags
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit          ENABLE_BRANCH  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic       Mem_ready,
  output logic       Mem_req,
  output logic       Mem_w,
  output logic       IorD,
  output logic       IR_w,
  output logic       PC_w,
  output logic       PC_wcond,
  output logic [1:0] PC_src,
  output logic       ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [1:0] ALU_op,
  output logic       Reg_dst,
  output logic       Reg_w,
  output logic       Mem_to_reg,
  output logic       Illegal,
  output logic       Timeout
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          r_state_q, w_state_d;
  logic [CntW-1:0] r_cnt_q, w_cnt_d;
  logic            r_illegal_q, r_timeout_q;
  logic            w_set_illegal, w_set_timeout;
  ins_class_t      w_class;
  logic            w_illegal;

  mc_opcode_decode #(
    .ENABLE_BRANCH(ENABLE_BRANCH)
  ) u_decode (
    .i_opcode (OpCode),
    .o_class  (w_class),
    .o_illegal(w_illegal)
  );

  // State register, wait counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q   <= StIdle;
      r_cnt_q     <= '0;
      r_illegal_q <= 1'b0;
      r_timeout_q <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      if (w_set_illegal) r_illegal_q <= 1'b1;
      if (w_set_timeout) r_timeout_q <= 1'b1;
    end
  end

  // Next state. The counter defaults to zero, so it is clear on every entry
  // to a memory state and after every completed handshake.
  always_comb begin
    w_state_d     = r_state_q;
    w_cnt_d       = '0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;

    if (is_mem_state(r_state_q) && !Mem_ready) begin
      if (r_cnt_q == CntLast) begin
        w_state_d     = StError;
        w_set_timeout = 1'b1;
      end else begin
        w_cnt_d = r_cnt_q + CntW'(1);
      end
    end else begin
      unique case (r_state_q)
        StIdle:   w_state_d = StFetch;
        StFetch:  w_state_d = StDecode;
        StDecode: begin
          if (w_illegal) begin
            w_state_d     = StError;
            w_set_illegal = 1'b1;
          end else begin
            unique case (1'b1)
              w_class.r:                 w_state_d = StExecR;
              w_class.addiu, w_class.ori: w_state_d = StExecI;
              w_class.lw, w_class.sw:    w_state_d = StMemAddr;
              w_class.beq:               w_state_d = StBranch;
              w_class.j:                 w_state_d = StJump;
              default:                   w_state_d = StError;
            endcase
          end
        end
        StExecR:   w_state_d = StWbR;
        StExecI:   w_state_d = StWbI;
        StWbR:     w_state_d = StFetch;
        StWbI:     w_state_d = StFetch;
        StMemAddr: w_state_d = w_class.sw ? StMemWr : StMemRd;
        StMemRd:   w_state_d = StMemWb;
        StMemWr:   w_state_d = StFetch;
        StMemWb:   w_state_d = StFetch;
        StBranch:  w_state_d = StFetch;
        StJump:    w_state_d = StFetch;
        StError:   w_state_d = StError;
        default:   w_state_d = StIdle;
      endcase
    end
  end

  // Outputs: Moore per state, except IR_w/PC_w in FETCH which follow Mem_ready.
  always_comb begin
    Mem_req    = 1'b0;
    Mem_w      = 1'b0;
    IorD       = 1'b0;
    IR_w       = 1'b0;
    PC_w       = 1'b0;
    PC_wcond   = 1'b0;
    PC_src     = PCSRC_ALU;
    ALU_srcA   = 1'b0;
    ALU_srcB   = SRCB_REG;
    ALU_op     = ALUOP_ADD;
    Reg_dst    = 1'b0;
    Reg_w      = 1'b0;
    Mem_to_reg = 1'b0;

    unique case (r_state_q)
      StFetch: begin
        Mem_req  = 1'b1;
        ALU_srcB = SRCB_FOUR;
        IR_w     = Mem_ready;
        PC_w     = Mem_ready;
      end
      StDecode: ALU_srcB = SRCB_IMM_SH;
      StExecR: begin
        ALU_srcA = 1'b1;
        ALU_op   = ALUOP_FUNCT;
      end
      StExecI: begin
        ALU_srcA = 1'b1;
        ALU_srcB = SRCB_IMM;
        ALU_op   = w_class.ori ? ALUOP_OR : ALUOP_ADD;
      end
      StWbR: begin
        Reg_dst = 1'b1;
        Reg_w   = 1'b1;
      end
      StWbI: Reg_w = 1'b1;
      StMemAddr: begin
        ALU_srcA = 1'b1;
        ALU_srcB = SRCB_IMM;
      end
      StMemRd: begin
        Mem_req = 1'b1;
        IorD    = 1'b1;
      end
      StMemWr: begin
        Mem_req = 1'b1;
        Mem_w   = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        Mem_to_reg = 1'b1;
        Reg_w      = 1'b1;
      end
      StBranch: begin
        ALU_srcA = 1'b1;
        ALU_op   = ALUOP_SUB;
        PC_wcond = 1'b1;
        PC_src   = PCSRC_ALUOUT;
      end
      StJump: begin
        PC_w   = 1'b1;
        PC_src = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign Illegal = r_illegal_q;
  assign Timeout = r_timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OpCode;
  logic       Mem_ready;

  logic       Mem_req, Mem_w, IorD, IR_w, PC_w, PC_wcond, ALU_srcA;
  logic [1:0] PC_src, ALU_srcB, ALU_op;
  logic       Reg_dst, Reg_w, Mem_to_reg, Illegal, Timeout;

  logic       n_req, n_w, n_iord, n_irw, n_pcw, n_pcwc, n_srca;
  logic [1:0] n_pcsrc, n_srcb, n_aluop;
  logic       n_regdst, n_regw, n_m2r, n_ill, n_to;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ENABLE_BRANCH(1'b1), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Mem_ready(Mem_ready),
    .Mem_req(Mem_req), .Mem_w(Mem_w), .IorD(IorD), .IR_w(IR_w), .PC_w(PC_w),
    .PC_wcond(PC_wcond), .PC_src(PC_src), .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB),
    .ALU_op(ALU_op), .Reg_dst(Reg_dst), .Reg_w(Reg_w), .Mem_to_reg(Mem_to_reg),
    .Illegal(Illegal), .Timeout(Timeout)
  );

  multicycle_control #(.ENABLE_BRANCH(1'b0), .TIMEOUT_CYCLES(16)) dut_nb (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Mem_ready(Mem_ready),
    .Mem_req(n_req), .Mem_w(n_w), .IorD(n_iord), .IR_w(n_irw), .PC_w(n_pcw),
    .PC_wcond(n_pcwc), .PC_src(n_pcsrc), .ALU_srcA(n_srca), .ALU_srcB(n_srcb),
    .ALU_op(n_aluop), .Reg_dst(n_regdst), .Reg_w(n_regw), .Mem_to_reg(n_m2r),
    .Illegal(n_ill), .Timeout(n_to)
  );

  // {Mem_req,Mem_w,IorD,IR_w,PC_w,PC_wcond,PC_src,ALU_srcA,ALU_srcB,ALU_op,
  //  Reg_dst,Reg_w,Mem_to_reg,Illegal,Timeout}
  logic [17:0] obs, obs_nb;
  assign obs = {Mem_req, Mem_w, IorD, IR_w, PC_w, PC_wcond, PC_src, ALU_srcA, ALU_srcB,
                ALU_op, Reg_dst, Reg_w, Mem_to_reg, Illegal, Timeout};
  assign obs_nb = {n_req, n_w, n_iord, n_irw, n_pcw, n_pcwc, n_pcsrc, n_srca, n_srcb,
                   n_aluop, n_regdst, n_regw, n_m2r, n_ill, n_to};

  //                  rq w  io ir pc pcc pcsrc sA srcB  aluop rd rw m2r il to
  localparam logic [17:0] E_IDLE   = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [17:0] E_FET_W  = 18'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0;
  localparam logic [17:0] E_FET_R  = 18'b1_0_0_1_1_0_00_0_01_00_0_0_0_0_0;
  localparam logic [17:0] E_DEC    = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0;
  localparam logic [17:0] E_EXR    = 18'b0_0_0_0_0_0_00_1_00_10_0_0_0_0_0;
  localparam logic [17:0] E_WBR    = 18'b0_0_0_0_0_0_00_0_00_00_1_1_0_0_0;
  localparam logic [17:0] E_EXORI  = 18'b0_0_0_0_0_0_00_1_10_11_0_0_0_0_0;
  localparam logic [17:0] E_WBI    = 18'b0_0_0_0_0_0_00_0_00_00_0_1_0_0_0;
  localparam logic [17:0] E_MADDR  = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
  localparam logic [17:0] E_MRD    = 18'b1_0_1_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [17:0] E_MWR    = 18'b1_1_1_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [17:0] E_MWB    = 18'b0_0_0_0_0_0_00_0_00_00_0_1_1_0_0;
  localparam logic [17:0] E_BR     = 18'b0_0_0_0_0_1_01_1_00_01_0_0_0_0_0;
  localparam logic [17:0] E_JMP    = 18'b0_0_0_0_1_0_10_0_00_00_0_0_0_0_0;
  localparam logic [17:0] E_ERRILL = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_1_0;
  localparam logic [17:0] E_ERRTO  = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_0_1;

  task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Advance one clock, then apply inputs for the new cycle and let outputs settle.
  task automatic at(input logic rdy, input logic [5:0] op);
    @(posedge clk);
    #1;
    Mem_ready = rdy;
    OpCode    = op;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_async_idle", obs, E_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", obs, E_IDLE);
  endtask

  initial begin
    rst_n     = 1'b0;
    Mem_ready = 1'b0;
    OpCode    = RT;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs, E_IDLE);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    Mem_ready = 1'b1;
    OpCode    = LW;
    #1;
    chk("idle_first_cycle", obs, E_IDLE);

    // lw, zero-wait memory: Reg_w/Mem_to_reg on the 6th cycle.
    at(1'b1, LW); chk("lw_fetch", obs, E_FET_R);
    at(1'b1, LW); chk("lw_decode", obs, E_DEC);
    at(1'b1, LW); chk("lw_mem_addr", obs, E_MADDR);
    at(1'b1, LW); chk("lw_mem_rd", obs, E_MRD);
    at(1'b1, LW); chk("lw_mem_wb", obs, E_MWB);

    // R-type with three wait cycles in FETCH.
    at(1'b0, RT); chk("r_fetch_wait1", obs, E_FET_W);
    at(1'b0, RT); chk("r_fetch_wait2", obs, E_FET_W);
    at(1'b0, RT); chk("r_fetch_wait3", obs, E_FET_W);
    at(1'b1, RT); chk("r_fetch_ready", obs, E_FET_R);
    at(1'b0, RT); chk("r_decode", obs, E_DEC);
    at(1'b0, RT); chk("r_exec", obs, E_EXR);
    at(1'b0, RT); chk("r_wb", obs, E_WBR);

    // ori: ALU_op=11 in EXEC_I.
    at(1'b1, ORI); chk("ori_fetch", obs, E_FET_R);
    at(1'b1, ORI); chk("ori_decode", obs, E_DEC);
    at(1'b1, ORI); chk("ori_exec", obs, E_EXORI);
    at(1'b1, ORI); chk("ori_wb", obs, E_WBI);

    // beq: legal here, illegal on the no-branch instance.
    at(1'b1, BEQ); chk("beq_fetch", obs, E_FET_R);
    at(1'b1, BEQ); chk("beq_decode", obs, E_DEC);
    at(1'b1, BEQ); chk("beq_branch", obs, E_BR);
    chk("nb_beq_illegal", obs_nb, E_ERRILL);

    // j
    at(1'b1, JMP); chk("j_fetch", obs, E_FET_R);
    at(1'b1, JMP); chk("j_decode", obs, E_DEC);
    at(1'b1, JMP); chk("j_jump", obs, E_JMP);
    chk("nb_illegal_sticky", obs_nb, E_ERRILL);

    // sw, ready on the 16th MEM_WR cycle: handshake wins.
    at(1'b1, SW); chk("sw_fetch", obs, E_FET_R);
    at(1'b1, SW); chk("sw_decode", obs, E_DEC);
    at(1'b1, SW); chk("sw_mem_addr", obs, E_MADDR);
    for (int i = 1; i <= 15; i++) begin
      at(1'b0, SW);
      chk($sformatf("sw_wr_wait%0d", i), obs, E_MWR);
    end
    at(1'b1, SW); chk("sw_wr_ready16", obs, E_MWR);
    at(1'b0, RT); chk("sw_no_timeout_fetch", obs, E_FET_W);
    at(1'b1, SW); chk("sw2_fetch", obs, E_FET_R);

    // sw, no ready for 16 MEM_WR cycles: timeout.
    at(1'b1, SW); chk("sw2_decode", obs, E_DEC);
    at(1'b1, SW); chk("sw2_mem_addr", obs, E_MADDR);
    for (int i = 1; i <= 16; i++) begin
      at(1'b0, SW);
      chk($sformatf("sw2_wr_wait%0d", i), obs, E_MWR);
    end
    at(1'b1, SW); chk("timeout_error", obs, E_ERRTO);
    at(1'b1, RT); chk("timeout_sticky", obs, E_ERRTO);

    do_reset();

    // Illegal opcode.
    at(1'b1, BAD); chk("bad_fetch", obs, E_FET_R);
    at(1'b1, BAD); chk("bad_decode", obs, E_DEC);
    at(1'b1, RT);  chk("bad_error", obs, E_ERRILL);
    at(1'b0, LW);  chk("bad_error_hold1", obs, E_ERRILL);
    at(1'b1, SW);  chk("bad_error_hold2", obs, E_ERRILL);

    do_reset();

    // Reset asserted during MEM_WR.
    at(1'b1, SW); chk("rst_sw_fetch", obs, E_FET_R);
    at(1'b1, SW); chk("rst_sw_decode", obs, E_DEC);
    at(1'b0, SW); chk("rst_sw_mem_addr", obs, E_MADDR);
    at(1'b0, SW); chk("rst_sw_mem_wr", obs, E_MWR);
    #2;
    do_reset();
    at(1'b0, RT); chk("restart_fetch", obs, E_FET_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
